// File: rtl/operand_serializer.sv
// Parallel-to-serial operand feeder for a bit-serial downstream stage.
// Presents a/b LSB first and collects the returned sum bits into result.
module operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             x,
    output logic             y,
    output logic             bit_valid,
    input  logic             sum_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 on the final bit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a  <= '0;
            shift_b  <= '0;
            result_q <= '0;
            cnt      <= '0;
        end else if (state == IDLE && start) begin
            shift_a  <= a;
            shift_b  <= b;
            result_q <= '0;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            shift_a  <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b  <= {1'b0, shift_b[WIDTH-1:1]};
            result_q <= {sum_in, result_q[WIDTH-1:1]};
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        x         = 1'b0;
        y         = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            SHIFT: begin
                x         = shift_a[0];
                y         = shift_b[0];
                bit_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign result = result_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Directed self-checking bench for operand_serializer at WIDTH=8 and WIDTH=2.
module tb_operand_serializer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    logic       y;
    logic       bit_valid;
    logic       sum_in;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic [1:0] mode;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       x2;
    logic       y2;
    logic       bit_valid2;
    logic       sum_in2;
    logic [1:0] result2;
    logic       busy2;
    logic       done2;

    int checks = 0;
    int failures = 0;

    operand_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .x(x), .y(y), .bit_valid(bit_valid), .sum_in(sum_in),
        .result(result), .busy(busy), .done(done)
    );

    operand_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .x(x2), .y(y2), .bit_valid(bit_valid2), .sum_in(sum_in2),
        .result(result2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream bit stage model: 0 xor, 1 and, 2 pass x, 3 or.
    always_comb begin
        sum_in = x ^ y;
        case (mode)
            2'd1: sum_in = x & y;
            2'd2: sum_in = x;
            2'd3: sum_in = x | y;
            default: sum_in = x ^ y;
        endcase
    end

    assign sum_in2 = x2 | y2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] xa;
        logic [7:0] xb;
        logic [7:0] ea;
        logic [7:0] eb;
        int n;
        int nd;

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        mode   = 2'd0;
        start2 = 1'b0;
        a2     = 2'b00;
        b2     = 2'b00;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_valid", {31'd0, bit_valid}, 32'd0);
        check("reset_xy", {30'd0, x, y}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // A5 ^ 3C, single-cycle start
        mode  = 2'd0;
        a     = 8'hA5;
        b     = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        xa = 8'hA5;
        xb = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("xor_x%0d", i), {31'd0, x}, {31'd0, xa[i]});
            check($sformatf("xor_y%0d", i), {31'd0, y}, {31'd0, xb[i]});
            check($sformatf("xor_valid%0d", i), {31'd0, bit_valid}, 32'd1);
            check($sformatf("xor_done%0d", i), {31'd0, done}, 32'd0);
            tick();
        end
        check("xor_done", {31'd0, done}, 32'd1);
        check("xor_done_valid", {31'd0, bit_valid}, 32'd0);
        check("xor_done_xy", {30'd0, x, y}, 32'd0);
        check("xor_result", {24'd0, result}, 32'h99);
        tick();
        check("xor_done_clear", {31'd0, done}, 32'd0);
        check("xor_idle_busy", {31'd0, busy}, 32'd0);
        check("xor_result_hold", {24'd0, result}, 32'h99);

        // FF & 0F, count busy cycles and done pulses
        mode  = 2'd1;
        a     = 8'hFF;
        b     = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        n  = 0;
        nd = 0;
        while (busy && n < 20) begin
            n++;
            if (done) nd++;
            tick();
        end
        check("and_busy_cycles", n, 32'd9);
        check("and_done_pulses", nd, 32'd1);
        check("and_result", {24'd0, result}, 32'h0F);

        // start held high: back-to-back operations with one IDLE gap
        mode  = 2'd2;
        a     = 8'h01;
        b     = 8'h00;
        start = 1'b1;
        tick();
        for (int op = 0; op < 2; op++) begin
            n = 0;
            while (busy && n < 20) begin
                n++;
                tick();
            end
            check($sformatf("held_busy%0d", op), n, 32'd9);
            check($sformatf("held_result%0d", op), {24'd0, result}, 32'h01);
            n = 0;
            while (!busy && n < 5) begin
                n++;
                tick();
            end
            check($sformatf("held_idle%0d", op), n, 32'd1);
        end
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check("held_final_result", {24'd0, result}, 32'h01);

        // operand churn and start pulses during SHIFT
        mode  = 2'd0;
        a     = 8'hA5;
        b     = 8'h3C;
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            a     = 8'h5A ^ 8'(i * 37);
            b     = 8'hC3 + 8'(i);
            start = i[0];
            check($sformatf("churn_x%0d", i), {31'd0, x}, {31'd0, xa[i]});
            check($sformatf("churn_y%0d", i), {31'd0, y}, {31'd0, xb[i]});
            tick();
        end
        start = 1'b0;
        check("churn_done", {31'd0, done}, 32'd1);
        check("churn_result", {24'd0, result}, 32'h99);
        tick();

        // asynchronous reset after the 4th bit
        mode  = 2'd0;
        a     = 8'hA5;
        b     = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_valid", {31'd0, bit_valid}, 32'd0);
        check("arst_xy", {30'd0, x, y}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", {24'd0, result}, 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        check("arst_no_done", nd, 32'd0);
        check("arst_idle", {31'd0, busy}, 32'd0);

        // recovery: 3C & A5 = 24
        mode  = 2'd1;
        a     = 8'h3C;
        b     = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        ea = 8'h3C;
        eb = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rec_x%0d", i), {31'd0, x}, {31'd0, ea[i]});
            check($sformatf("rec_y%0d", i), {31'd0, y}, {31'd0, eb[i]});
            tick();
        end
        check("rec_done", {31'd0, done}, 32'd1);
        check("rec_result", {24'd0, result}, 32'h24);
        tick();

        // WIDTH=2: 10 | 01 = 11
        a2     = 2'b10;
        b2     = 2'b01;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n  = 0;
        nd = 0;
        while (!done2 && n < 10) begin
            if (bit_valid2) n++;
            tick();
        end
        check("w2_valid_bits", n, 32'd2);
        check("w2_done", {31'd0, done2}, 32'd1);
        check("w2_result", {30'd0, result2}, 32'd3);
        tick();
        check("w2_idle", {31'd0, busy2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to serialize the operands presented on a and b.
REQ-005 The block SHALL have port a, input, WIDTH, first parallel operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH, second parallel operand, sampled only when start is accepted.
REQ-007 The block SHALL have port x, output, 1, current bit of a to the downstream bit stage, LSB first.
REQ-008 The block SHALL have port y, output, 1, current bit of b to the downstream bit stage, LSB first.
REQ-009 The block SHALL have port bit_valid, output, 1, high while x and y carry a live bit pair.
REQ-010 The block SHALL have port sum_in, input, 1, combinational return bit from the downstream stage, valid in the same cycle as x and y.
REQ-011 The block SHALL have port result, output, WIDTH, collected sum_in bits, LSB = first bit.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse when result is complete.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE; all outputs SHALL be registered or decoded from state only.
REQ-015 In IDLE with start=1 at a clock edge, the block SHALL load a and b into shift registers, clear the bit counter to 0, clear result to 0 and enter SHIFT.
REQ-016 start SHALL be ignored in SHIFT and DONE; operand changes outside acceptance SHALL have no effect.
REQ-017 In SHIFT, x SHALL equal shift_a[0], y SHALL equal shift_b[0] and bit_valid SHALL be 1.
REQ-018 Each SHIFT edge SHALL shift result right with sum_in entering the MSB, shift both operand registers right by one with 0 fill, and increment the counter.
REQ-019 SHIFT SHALL transition to DONE on the edge at which the counter equals WIDTH-1, so exactly WIDTH bit pairs are presented.
REQ-020 Latency: if start is accepted at edge N, bit_valid SHALL be high for the cycles after edges N..N+WIDTH-1 and done SHALL be high for the single cycle after edge N+WIDTH.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; start asserted during DONE is not accepted, and start held high is accepted in the following IDLE cycle.
REQ-022 result SHALL hold its value from DONE until the next accepted start.
REQ-023 x and y SHALL be 0 whenever bit_valid is 0.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, x=0, y=0, bit_valid=0, busy=0, done=0, result=0, and clear the counter and shift registers.
REQ-026 Reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse; the first start accepted after release SHALL behave as from power-up.

Verification
REQ-027 WIDTH=8, sum_in=x^y, start 1 cycle with a=8'hA5 and b=8'h3C -> x sequence 1,0,1,0,0,1,0,1; y sequence 0,0,1,1,1,1,0,0; done one cycle after the 8th bit; result=8'h99.
REQ-028 WIDTH=8, sum_in=x&y, a=8'hFF, b=8'h0F -> result=8'h0F; busy high for exactly 9 cycles.
REQ-029 start held high continuously, a=8'h01, b=8'h00, sum_in=x -> back-to-back operations each of 9 busy cycles, separated by exactly 1 IDLE cycle, each giving result=8'h01.
REQ-030 Operands change and start pulses during SHIFT -> no effect on the x/y sequence or the final result.
REQ-031 rst_n pulled low asynchronously after the 4th bit -> all outputs are 0 at once, no done pulse follows, and the next operation is correct.
REQ-032 WIDTH=2, a=2'b10, b=2'b01, sum_in=x|y -> exactly 2 valid bits and result=2'b11.
